// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM types plus operation-class helpers for seq_alu
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'h00,
        OP_SUB    = 5'h01,
        OP_AND    = 5'h02,
        OP_OR     = 5'h03,
        OP_XOR    = 5'h04,
        OP_SLL    = 5'h05,
        OP_SRL    = 5'h06,
        OP_SRA    = 5'h07,
        OP_SLT    = 5'h08,
        OP_SLTU   = 5'h09,
        OP_MUL    = 5'h10,
        OP_MULH   = 5'h11,
        OP_MULHSU = 5'h12,
        OP_MULHU  = 5'h13,
        OP_DIV    = 5'h14,
        OP_DIVU   = 5'h15,
        OP_REM    = 5'h16,
        OP_REMU   = 5'h17
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // M group occupies 0x10..0x17
    function automatic logic is_muldiv(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    function automatic logic is_signed_a(input logic [4:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [4:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         abandon the running operation
//   start         load operands and begin XLEN steps
//   op, a, b      M-group opcode and operands (sampled on start)
//   done          high during the final step; result valid in that cycle
//   result        sign-corrected result of the final step
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    // acc: multiply = {partial product, remaining multiplier bits}
    //      divide   = {partial remainder, dividend / quotient bits}
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   mb;
    logic [XLEN-1:0]   ma_in;
    logic [XLEN-1:0]   mb_in;
    logic [XLEN-1:0]   part;
    logic [SHW-1:0]    cnt;
    logic              active;
    logic              is_div;
    logic              neg;
    logic              sel_hi;
    logic              sa;
    logic              sb;
    logic [XLEN:0]     mul_hi;
    logic [XLEN:0]     div_sh;
    logic [XLEN:0]     div_df;

    always_comb begin
        sa    = is_signed_a(op) && a[XLEN-1];
        sb    = is_signed_b(op) && b[XLEN-1];
        ma_in = sa ? -a : a;
        mb_in = sb ? -b : b;
    end

    always_comb begin
        mul_hi = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mb} : {(XLEN+1){1'b0}});
        div_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_df = div_sh - {1'b0, mb};
        if (is_div) begin
            // restoring step: keep the difference only if it did not go negative
            if (!div_df[XLEN]) begin
                acc_nxt = {div_df[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {mul_hi, acc[XLEN-1:1]};
        end
    end

    // Products are negated as a whole 2*XLEN value; quotient/remainder
    // are negated independently after selecting the half.
    always_comb begin
        prod_fix = neg ? -acc_nxt : acc_nxt;
        part     = sel_hi ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
        if (is_div) begin
            result = neg ? -part : part;
        end else begin
            result = sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        end
    end

    assign done = active && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mb     <= '0;
            cnt    <= '0;
            active <= 1'b0;
            is_div <= 1'b0;
            neg    <= 1'b0;
            sel_hi <= 1'b0;
        end else if (flush) begin
            active <= 1'b0;
        end else if (start) begin
            acc    <= {{XLEN{1'b0}}, ma_in};
            mb     <= mb_in;
            cnt    <= SHW'(XLEN - 1);
            active <= 1'b1;
            is_div <= op[2];
            neg    <= ((op == OP_REM) || (op == OP_REMU)) ? sa : (sa ^ sb);
            sel_hi <= (op != OP_MUL) && (op != OP_DIV) && (op != OP_DIVU);
        end else if (active) begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked execute unit: base ALU plus iterative mul/div
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous abort of any in-flight op
//   in_valid, in_ready   issue handshake; A, B, ALUOp sampled on accept
//   out_valid, out_ready result handshake with backpressure
//   Result               registered result
//   Zero, Carry, Overflow registered flags for Result
module seq_alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [4:0]      ALUOp,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            Zero,
    output logic            Carry,
    output logic            Overflow
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state;
    state_e          state_nxt;
    logic            accept;
    logic            special;
    logic            use_iter;
    logic [XLEN-1:0] fast_res;
    logic            fast_c;
    logic            fast_v;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   dif;
    logic [SHW-1:0]  shamt;
    logic            b_zero;
    logic            div_ovf;
    logic            md_done;
    logic [XLEN-1:0] md_res;

    // flush wins over a same-cycle issue even though in_ready may be high
    assign accept   = in_valid && in_ready && !flush;
    assign use_iter = is_muldiv(ALUOp) && !special;

    // Single-cycle path: base ops, divide special cases, unknown codes
    always_comb begin
        sum      = {1'b0, A} + {1'b0, B};
        dif      = {1'b0, A} - {1'b0, B};
        shamt    = B[SHW-1:0];
        b_zero   = (B == '0);
        div_ovf  = (A == MIN_NEG) && (B == '1);
        fast_res = '0;
        fast_c   = 1'b0;
        fast_v   = 1'b0;
        special  = 1'b0;
        case (ALUOp)
            OP_ADD: begin
                fast_res = sum[XLEN-1:0];
                fast_c   = sum[XLEN];
                fast_v   = (A[XLEN-1] == B[XLEN-1]) && (sum[XLEN-1] != A[XLEN-1]);
            end
            OP_SUB: begin
                fast_res = dif[XLEN-1:0];
                fast_c   = dif[XLEN];
                fast_v   = (A[XLEN-1] != B[XLEN-1]) && (dif[XLEN-1] != A[XLEN-1]);
            end
            OP_AND:  fast_res = A & B;
            OP_OR:   fast_res = A | B;
            OP_XOR:  fast_res = A ^ B;
            OP_SLL:  fast_res = A << shamt;
            OP_SRL:  fast_res = A >> shamt;
            OP_SRA:  fast_res = $signed(A) >>> shamt;
            OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, A < B};
            OP_DIV: begin
                if (b_zero) begin
                    special  = 1'b1;
                    fast_res = '1;
                end else if (div_ovf) begin
                    special  = 1'b1;
                    fast_res = A;
                end
            end
            OP_DIVU: begin
                if (b_zero) begin
                    special  = 1'b1;
                    fast_res = '1;
                end
            end
            OP_REM: begin
                if (b_zero) begin
                    special  = 1'b1;
                    fast_res = A;
                end else if (div_ovf) begin
                    special  = 1'b1;
                    fast_res = '0;
                end
            end
            OP_REMU: begin
                if (b_zero) begin
                    special  = 1'b1;
                    fast_res = A;
                end
            end
            default: fast_res = '0;
        endcase
    end

    muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .start (accept && use_iter),
        .op    (ALUOp),
        .a     (A),
        .b     (B),
        .done  (md_done),
        .result(md_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = use_iter ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_nxt = use_iter ? BUSY : DONE;
                end else if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
    end

    // Result only changes on a new single-cycle accept or the final
    // iterative step, so it stays stable while DONE waits for out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result   <= '0;
            Zero     <= 1'b0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else if (!flush) begin
            if (accept && !use_iter) begin
                Result   <= fast_res;
                Zero     <= (fast_res == '0);
                Carry    <= fast_c;
                Overflow <= fast_v;
            end else if ((state == BUSY) && md_done) begin
                Result   <= md_res;
                Zero     <= (md_res == '0);
                Carry    <= 1'b0;
                Overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu at XLEN=32
module tb_seq_alu;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  ALUOp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Zero;
    logic        Carry;
    logic        Overflow;

    int checks = 0;
    int errors = 0;
    logic auto_release = 1'b0;

    typedef struct {
        string       tag;
        logic [34:0] val;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    seq_alu #(
        .XLEN(XLEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .ALUOp    (ALUOp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Result   (Result),
        .Zero     (Zero),
        .Carry    (Carry),
        .Overflow (Overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {Zero, Carry, Overflow, Result} from wide native arithmetic
    function automatic logic [34:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        logic        v;
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      ub;
        c  = 1'b0;
        v  = 1'b0;
        r  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'(b);
        case (op)
            5'h00: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            5'h01: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            5'h02: r = a & b;
            5'h03: r = a | b;
            5'h04: r = a ^ b;
            5'h05: r = a << b[4:0];
            5'h06: r = a >> b[4:0];
            5'h07: r = $signed(a) >>> b[4:0];
            5'h08: r = {31'd0, $signed(a) < $signed(b)};
            5'h09: r = {31'd0, a < b};
            5'h10: begin p = sa * sb; r = p[31:0]; end
            5'h11: begin p = sa * sb; r = p[63:32]; end
            5'h12: begin p = sa * ub; r = p[63:32]; end
            5'h13: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            5'h14: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = $signed(a) / $signed(b);
            end
            5'h15: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'h16: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = $signed(a) % $signed(b);
            end
            5'h17: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return {(r == 32'd0), c, v, r};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("spurious_out", out_valid, 1'b0);
            end else begin
                e = sbq.pop_front();
                check(e.tag, {Zero, Carry, Overflow, Result}, e.val);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int   n;
        exp_t e;
        ALUOp    = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #1;
            if (auto_release) out_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({tag, "_issue_timeout"}, in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        e.tag = tag;
        e.val = model(op, a, b);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Number of clock edges after the accept edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          lat;
        time         t0;
        logic [31:0] edge_vals [6];
        logic [4:0]  ops [20];
        logic [31:0] ra;
        logic [31:0] rb;
        logic [34:0] prev;

        edge_vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd100};
        ops = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
                5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h0A, 5'h1F};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        ALUOp     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", {out_valid, in_ready, Zero, Carry, Overflow}, 5'b01000);
        check("rst_result", Result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue("add_ovf", 5'h00, 32'h7FFF_FFFF, 32'd1);
        wait_out(lat);
        check("add_lat", lat, 0);
        issue("sub_borrow", 5'h01, 32'd0, 32'd1);
        wait_out(lat);

        issue("mulh", 5'h11, 32'hFFFF_FFFE, 32'd3);
        wait_out(lat);
        check("mulh_lat", lat, 32);
        issue("mul", 5'h10, 32'hFFFF_FFFE, 32'd3);
        wait_out(lat);
        check("mul_lat", lat, 32);

        issue("div_by0", 5'h14, 32'd7, 32'd0);
        wait_out(lat);
        check("div_by0_lat", lat, 0);
        issue("rem_by0", 5'h16, 32'd7, 32'd0);
        wait_out(lat);
        issue("div_ovf", 5'h14, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_out(lat);
        check("div_ovf_lat", lat, 0);
        issue("rem_ovf", 5'h16, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_out(lat);

        issue("remu", 5'h17, 32'd100, 32'd7);
        wait_out(lat);
        check("remu_lat", lat, 32);
        issue("div_neg", 5'h14, 32'hFFFF_FF9C, 32'd7);
        wait_out(lat);
        issue("rem_neg", 5'h16, 32'hFFFF_FF9C, 32'd7);
        wait_out(lat);
        issue("mulhsu", 5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_out(lat);

        // backpressure hold with an XOR waiting behind it
        out_ready = 1'b0;
        issue("divu_hold", 5'h15, 32'd100, 32'd7);
        wait_out(lat);
        check("divu_lat", lat, 32);
        ALUOp    = 5'h04;
        A        = 32'hF0F0_1234;
        B        = 32'h0FF0_4321;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_result", Result, 32'd14);
            check("hold_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue("xor_b2b", 5'h04, 32'hF0F0_1234, 32'h0FF0_4321);
        wait_out(lat);
        check("xor_lat", lat, 0);

        // base ops sustain one per cycle
        t0 = $time;
        for (int i = 0; i < 8; i++) begin
            issue("b2b", ops[i], $urandom, $urandom);
        end
        check("b2b_cycles", ($time - t0) / 10, 8);
        wait_out(lat);

        // flush mid-divide
        issue("xor_pre", 5'h04, 32'h1234_5678, 32'h0000_FFFF);
        wait_out(lat);
        prev = model(5'h04, 32'h1234_5678, 32'h0000_FFFF);
        issue("div_flushed", 5'h14, 32'd1000, 32'd3);
        void'(sbq.pop_back());
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_result_kept", Result, prev[31:0]);
        repeat (40) @(posedge clk);
        #1;
        issue("add_after_flush", 5'h00, 32'd2, 32'd3);
        wait_out(lat);
        check("add_after_flush_lat", lat, 0);

        // asynchronous reset mid-multiply
        issue("mul_reset", 5'h10, 32'd5, 32'd6);
        void'(sbq.pop_back());
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_ctl", {out_valid, in_ready, Zero, Carry, Overflow}, 5'b01000);
        check("arst_result", Result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue("mul_after_rst", 5'h10, 32'hFFFF_FFFE, 32'd3);
        wait_out(lat);
        check("mul_after_rst_lat", lat, 32);

        // random mix with random backpressure
        auto_release = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ra = ($urandom_range(0, 7) > 5) ? $urandom : edge_vals[$urandom_range(0, 5)];
            rb = ($urandom_range(0, 7) > 5) ? $urandom : edge_vals[$urandom_range(0, 5)];
            out_ready = 1'($urandom_range(0, 1));
            issue("rand", ops[$urandom_range(0, 19)], ra, rb);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sbq.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
